// File: rtl/muldiv_sequencer.sv
// Iterative multiply (shift-add) / divide (restoring) sequencer for the MIPS execute stage.
// Define SIGNED_MULDIV_EN for two's-complement operands; default build is unsigned only.
module muldiv_sequencer #(
    parameter int          WIDTH  = 16,
    parameter logic [5:0]  OP_MUL = 6'b100000,
    parameter logic [5:0]  OP_DIV = 6'b100001
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       op_dec,
    input  logic             valid_in,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             flush,
    output logic             stall,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result_lo,
    output logic [WIDTH-1:0] result_hi,
    output logic [1:0]       flag_ex
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      count_q;
    logic               is_div_q;
    logic [WIDTH-1:0]   opa_q, opb_q;
    logic [2*WIDTH:0]   acc_q, acc_d;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [WIDTH:0]     upper;
    logic [2*WIDTH:0]   shifted;
    logic [WIDTH+1:0]   trial;
    logic [WIDTH-1:0]   fin_lo, fin_hi;
    logic [1:0]         fin_flag;
    logic               is_muldiv, is_div_op, accept, div_by_zero, last_iter;

`ifdef SIGNED_MULDIV_EN
    logic               neg_a_q, neg_b_q, sgn;
    logic [2*WIDTH-1:0] prod;

    function automatic logic [WIDTH-1:0] neg_w(input logic neg, input logic [WIDTH-1:0] v);
        return neg ? (~v + 1'b1) : v;
    endfunction

    function automatic logic [2*WIDTH-1:0] neg_2w(input logic neg, input logic [2*WIDTH-1:0] v);
        return neg ? (~v + 1'b1) : v;
    endfunction

    assign mag_a = neg_w(A[WIDTH-1], A);
    assign mag_b = neg_w(B[WIDTH-1], B);
`else
    assign mag_a = A;
    assign mag_b = B;
`endif

    assign is_div_op   = (op_dec == OP_DIV);
    assign is_muldiv   = (op_dec == OP_MUL) || is_div_op;
    assign accept      = (state_q == IDLE) && valid_in && is_muldiv && !flush;
    assign div_by_zero = is_div_op && (B == '0);
    assign last_iter   = (count_q == CW'(WIDTH - 1));

    assign busy  = (state_q == RUN);
    assign done  = (state_q == DONE);
    assign stall = busy || accept;

    // One iteration: mul adds into the upper half then shifts right; div shifts left and trial-subtracts.
    always_comb begin
        acc_d   = acc_q;
        upper   = acc_q[2*WIDTH:WIDTH];
        shifted = {acc_q[2*WIDTH-1:0], 1'b0};
        trial   = {1'b0, shifted[2*WIDTH:WIDTH]} - {2'b00, opb_q};
        if (is_div_q) begin
            if (!trial[WIDTH+1])
                acc_d = {trial[WIDTH:0], shifted[WIDTH-1:1], 1'b1};
            else
                acc_d = shifted;
        end else begin
            if (acc_q[0])
                upper = acc_q[2*WIDTH:WIDTH] + {1'b0, opa_q};
            acc_d = {1'b0, upper, acc_q[WIDTH-1:1]};
        end
    end

    always_comb begin
        fin_lo   = acc_d[WIDTH-1:0];
        fin_hi   = acc_d[2*WIDTH-1:WIDTH];
        fin_flag = 2'b00;
`ifdef SIGNED_MULDIV_EN
        sgn  = neg_a_q ^ neg_b_q;
        prod = neg_2w(sgn, acc_d[2*WIDTH-1:0]);
        if (is_div_q) begin
            // Remainder follows the dividend; a positive quotient of magnitude 2^(W-1) cannot be represented.
            fin_lo   = neg_w(sgn, acc_d[WIDTH-1:0]);
            fin_hi   = neg_w(neg_a_q, acc_d[2*WIDTH-1:WIDTH]);
            fin_flag = {(fin_lo == '0), (!sgn && acc_d[WIDTH-1])};
        end else begin
            fin_lo   = prod[WIDTH-1:0];
            fin_hi   = prod[2*WIDTH-1:WIDTH];
            fin_flag = {(prod == '0), (prod[2*WIDTH-1:WIDTH] != {WIDTH{prod[WIDTH-1]}})};
        end
`else
        if (is_div_q)
            fin_flag = {(acc_d[WIDTH-1:0] == '0), 1'b0};
        else
            fin_flag = {(acc_d[2*WIDTH-1:0] == '0), (acc_d[2*WIDTH-1:WIDTH] != '0)};
`endif
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = div_by_zero ? DONE : RUN;
            RUN:     if (flush) state_d = IDLE;
                     else if (last_iter) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            count_q   <= '0;
            is_div_q  <= 1'b0;
            opa_q     <= '0;
            opb_q     <= '0;
            acc_q     <= '0;
            result_lo <= '0;
            result_hi <= '0;
            flag_ex   <= 2'b00;
`ifdef SIGNED_MULDIV_EN
            neg_a_q   <= 1'b0;
            neg_b_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            if (accept) begin
                count_q  <= '0;
                is_div_q <= is_div_op;
                opa_q    <= mag_a;
                opb_q    <= mag_b;
                acc_q    <= {1'b0, {WIDTH{1'b0}}, (is_div_op ? mag_a : mag_b)};
`ifdef SIGNED_MULDIV_EN
                neg_a_q  <= A[WIDTH-1];
                neg_b_q  <= B[WIDTH-1];
`endif
            end else if (state_q == RUN) begin
                count_q <= count_q + 1'b1;
                acc_q   <= acc_d;
            end
            // Results only change on entry to DONE.
            if (accept && div_by_zero) begin
                result_lo <= '1;
                result_hi <= A;
                flag_ex   <= 2'b01;
            end else if ((state_q == RUN) && last_iter && !flush) begin
                result_lo <= fin_lo;
                result_hi <= fin_hi;
                flag_ex   <= fin_flag;
            end
        end
    end
endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed self-checking bench for muldiv_sequencer; signed vectors run when SIGNED_MULDIV_EN is defined.
module tb_muldiv_sequencer;
    localparam logic [5:0] OP_MUL = 6'b100000;
    localparam logic [5:0] OP_DIV = 6'b100001;

    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  op_dec;
    logic        valid_in;
    logic [15:0] A, B;
    logic        flush;
    logic        stall, busy, done;
    logic [15:0] result_lo, result_hi;
    logic [1:0]  flag_ex;

    int total = 0;
    int bad   = 0;
    int lat;
    logic saw_done;

    muldiv_sequencer dut (
        .clk(clk), .reset(reset), .op_dec(op_dec), .valid_in(valid_in),
        .A(A), .B(B), .flush(flush), .stall(stall), .busy(busy), .done(done),
        .result_lo(result_lo), .result_hi(result_hi), .flag_ex(flag_ex)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Present one request for a single cycle and wait (bounded) for the done pulse.
    task automatic do_op(input logic [5:0] op, input logic [15:0] a, input logic [15:0] b, output int l);
        op_dec = op; A = a; B = b; valid_in = 1'b1;
        #1 check_val("stall_accept", stall, 1);
        @(negedge clk);
        valid_in = 1'b0;
        l = 1;
        while (done !== 1'b1 && l < 40) begin
            @(negedge clk);
            l++;
        end
    endtask

    task automatic check_res(input string tag, input int l, input int el,
                             input logic [15:0] hi, input logic [15:0] lo, input logic [1:0] fl);
        check_val({tag, "_lat"}, l, el);
        check_val({tag, "_hi"}, result_hi, hi);
        check_val({tag, "_lo"}, result_lo, lo);
        check_val({tag, "_flag"}, flag_ex, fl);
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b0; op_dec = '0; valid_in = 1'b0; A = '0; B = '0; flush = 1'b0;
        repeat (2) @(negedge clk);
        check_val("rst_stall", stall, 0);
        check_val("rst_busy", busy, 0);
        check_val("rst_done", done, 0);
        check_val("rst_res", {result_hi, result_lo}, 32'h0);
        check_val("rst_flag", flag_ex, 0);
        reset = 1'b1;
        @(negedge clk);

        do_op(OP_MUL, 16'd7, 16'd6, lat);
        check_val("mul7x6_busy_in_done", busy, 0);
        check_val("mul7x6_stall_in_done", stall, 0);
        check_res("mul7x6", lat, 17, 16'h0000, 16'h002A, 2'b00);

`ifndef SIGNED_MULDIV_EN
        do_op(OP_MUL, 16'hFFFF, 16'hFFFF, lat);
        check_res("mulffff", lat, 17, 16'hFFFE, 16'h0001, 2'b01);
`else
        do_op(OP_MUL, 16'hFFFF, 16'hFFFF, lat);
        check_res("smul_m1m1", lat, 17, 16'h0000, 16'h0001, 2'b00);
        do_op(OP_MUL, 16'hFFFA, 16'd7, lat);
        check_res("smul_m6x7", lat, 17, 16'hFFFF, 16'hFFD6, 2'b00);
        do_op(OP_DIV, 16'hFFF9, 16'd2, lat);
        check_res("sdiv_m7d2", lat, 17, 16'hFFFF, 16'hFFFD, 2'b00);
        do_op(OP_DIV, 16'h8000, 16'hFFFF, lat);
        check_res("sdiv_ovf", lat, 17, 16'h0000, 16'h8000, 2'b01);
`endif

        do_op(OP_MUL, 16'h0000, 16'h1234, lat);
        check_res("mul0", lat, 17, 16'h0000, 16'h0000, 2'b10);

        do_op(OP_DIV, 16'd100, 16'd7, lat);
        check_res("div100_7", lat, 17, 16'h0002, 16'h000E, 2'b00);

        do_op(OP_DIV, 16'h1234, 16'h0000, lat);
        check_res("div0", lat, 1, 16'h1234, 16'hFFFF, 2'b01);

        // Non-muldiv opcode must not stall or start anything.
        op_dec = 6'b000000; A = 16'd3; B = 16'd4; valid_in = 1'b1;
        #1 check_val("other_op_stall", stall, 0);
        @(negedge clk);
        check_val("other_op_busy", busy, 0);
        valid_in = 1'b0;

        // Flush at count 5: back to IDLE, no done, previous results held.
        op_dec = OP_MUL; A = 16'd9; B = 16'd9; valid_in = 1'b1;
        @(negedge clk);
        valid_in = 1'b0;
        repeat (5) @(negedge clk);
        check_val("flush_busy_before", busy, 1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check_val("flush_busy_after", busy, 0);
        check_val("flush_res_held", {result_hi, result_lo}, 32'h1234FFFF);
        check_val("flush_flag_held", flag_ex, 2'b01);
        saw_done = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (done === 1'b1) saw_done = 1'b1;
        end
        check_val("flush_no_done", saw_done, 0);

        // Flush and a request in the same IDLE cycle: request is dropped.
        op_dec = OP_MUL; A = 16'd2; B = 16'd2; valid_in = 1'b1; flush = 1'b1;
        #1 check_val("flush_accept_stall", stall, 0);
        @(negedge clk);
        flush = 1'b0; valid_in = 1'b0;
        check_val("flush_accept_busy", busy, 0);

        // Second request while busy is ignored, then taken in the cycle after DONE.
        op_dec = OP_MUL; A = 16'd2; B = 16'd3; valid_in = 1'b1;
        @(negedge clk);
        valid_in = 1'b0;
        @(negedge clk);
        A = 16'd4; B = 16'd5; valid_in = 1'b1;
        lat = 2;
        while (done !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check_val("b2b_first_lat", lat, 17);
        check_val("b2b_first_lo", result_lo, 16'd6);
        check_val("b2b_done_stall", stall, 0);
        @(negedge clk);
        #1 check_val("b2b_reaccept_stall", stall, 1);
        @(negedge clk);
        valid_in = 1'b0;
        lat = 1;
        while (done !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check_res("b2b_second", lat, 17, 16'h0000, 16'h0014, 2'b00);

        // Asynchronous reset at count 8.
        op_dec = OP_MUL; A = 16'd3; B = 16'd3; valid_in = 1'b1;
        @(negedge clk);
        valid_in = 1'b0;
        repeat (8) @(negedge clk);
        check_val("midrst_busy_before", busy, 1);
        reset = 1'b0;
        #1;
        check_val("midrst_busy", busy, 0);
        check_val("midrst_stall", stall, 0);
        check_val("midrst_done", done, 0);
        check_val("midrst_res", {result_hi, result_lo}, 32'h0);
        check_val("midrst_flag", flag_ex, 0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        do_op(OP_MUL, 16'd7, 16'd6, lat);
        check_res("post_rst_mul", lat, 17, 16'h0000, 16'h002A, 2'b00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
- Multi-cycle multiply/divide controller for the 16-bit MIPS execute stage.
- Takes multiply (op_dec 6'b100000) and divide (op_dec 6'b100001) out of the single-cycle ALU path and runs them as iterative shift-add and restoring-divide sequences.
- Stalls the pipeline while busy and returns a 32-bit HI/LO result with flags in the same {zero, overflow} format as the ALU flag_ex.

Parameters:
- WIDTH, 16, operand width; result is 2*WIDTH.
- OP_MUL, 6'b100000, op_dec code for multiply.
- OP_DIV, 6'b100001, op_dec code for divide.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- op_dec  input  6  decoded opcode from the decode stage.
- valid_in  input  1  op_dec, A and B are valid this cycle.
- A  input  WIDTH  multiplicand / dividend.
- B  input  WIDTH  multiplier / divisor.
- flush  input  1  synchronous abort of an in-flight operation.
- stall  output  1  holds the upstream pipeline.
- busy  output  1  sequencer is occupied (state RUN).
- done  output  1  one-cycle pulse; results valid.
- result_lo  output  WIDTH  product[15:0] or quotient.
- result_hi  output  WIDTH  product[31:16] or remainder.
- flag_ex  output  2  {zero, overflow}.

Behaviour:
- Reset (reset low, asynchronous): state=IDLE, count=0, operand/accumulator registers=0, result_lo=result_hi=0, flag_ex=2'b00, done=0, busy=0. stall is then 0 unless a request is present.
- accept = (state==IDLE) & valid_in & (op_dec==OP_MUL | op_dec==OP_DIV). Other opcodes are ignored: no state change, no stall.
- stall = busy | accept. This is combinational so the pipeline freezes in the accept cycle itself.
- IDLE, on accept:
  - Latch A, B and the op; clear count and the accumulator.
  - If the op is divide and B==0, go to DONE next. Otherwise go to RUN.
- RUN: one iteration per clock, count increments by 1.
  - MUL iteration: if multiplier LSB is 1, add multiplicand into the upper half of the 33-bit accumulator; then shift right 1.
  - DIV iteration: shift {rem,quo} left 1; trial-subtract divisor from rem; on no borrow, keep the difference and set quo LSB=1.
  - After the iteration with count==WIDTH-1, go to DONE.
- DONE (exactly one cycle): done=1, busy=0, stall=0. Pipeline advances and captures results. Next state is IDLE.
- Latency: done is asserted WIDTH+1 = 17 clocks after the accept edge. For divide-by-zero it is 1 clock after.
- result_lo, result_hi and flag_ex are registered and only update on entry to DONE. They hold their values until the next DONE or reset.
- Flags, multiply:
  - zero = (product==0).
  - overflow = (result_hi != 0), i.e. the product does not fit in 16 bits.
- Flags, divide:
  - zero = (quotient==0).
  - overflow = divide-by-zero.
  - B==0 result: quotient=16'hFFFF, remainder=A, flag_ex={0,1}.
- flush in RUN: return to IDLE next cycle. No done pulse; result registers and flags unchanged. flush in IDLE or DONE has no effect.
- flush and accept in the same cycle: flush wins and the request is not accepted.
- valid_in while busy is ignored. Upstream holds the request because stall=1.
- A back-to-back request in the DONE cycle is not accepted (state is not IDLE). It is accepted the following cycle.
- Reset asserted mid-RUN: immediate return to IDLE with all outputs at reset values.

Optional Feature:
- Macro: SIGNED_MULDIV_EN.
- Defined:
  - Operands are two's complement. Magnitudes are taken at accept and the sign is applied on entry to DONE.
  - Division truncates toward zero; the remainder takes the sign of the dividend.
  - Multiply overflow = result_hi is not the sign-extension of result_lo[15].
  - -32768 / -1 gives quotient 16'h8000, remainder 0, overflow=1.
  - Latency is unchanged.
- Not defined: all operands are unsigned as described above, and no sign-correction logic is synthesised.

Test Plan:
- MUL 7*6, valid_in for 1 cycle -> stall high from the accept cycle; done 17 clocks later; result_hi=16'h0000, result_lo=16'h002A, flag_ex=2'b00.
- Unsigned MUL 16'hFFFF*16'hFFFF -> result_hi=16'hFFFE, result_lo=16'h0001, flag_ex=2'b01. MUL 0*16'h1234 -> result 0, flag_ex=2'b10.
- DIV 100/7 -> result_lo=16'h000E, result_hi=16'h0002, flag_ex=2'b00. DIV 16'h1234/0 -> done 1 clock after accept, result_lo=16'hFFFF, result_hi=16'h1234, flag_ex=2'b01.
- Start MUL, assert flush at count 5 -> IDLE next cycle, no done, previous results held. Separately, drop reset at count 8 -> busy=0, all outputs 0 immediately.
- A non-muldiv op (6'b000000) with valid_in -> no stall. A second MUL while busy -> ignored until it is re-presented after DONE.
- With SIGNED_MULDIV_EN: -6*7 -> result_hi=16'hFFFF, result_lo=16'hFFD6, flag_ex=2'b00. -7/2 -> quotient 16'hFFFD, remainder 16'hFFFF. 16'h8000/16'hFFFF -> overflow=1.
